// File: rtl/fifo_test_pkg.sv
// Shared definitions for the FIFO test design: the state encoding used by both
// the read-side (RSTATE) and write-side (WSTATE) controllers, and the data
// pattern the write side produces and the read side checks.
package fifo_test_pkg;

    // Encoding is visible on the logic analyser, so the values are fixed.
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        READ  = 4'd1,
        DRAIN = 4'd2,
        DONE  = 4'd3
    } fifo_state_e;

    // Word idx of a burst is seed + idx; callers keep only their data width.
    function automatic logic [31:0] next(input logic [31:0] seed, input logic [31:0] idx);
        return seed + idx;
    endfunction

endpackage

// File: rtl/fifo_rd_checker.sv
// Read-side controller for the FIFO test design. Drains BURST_LEN words from
// the FIFO read port and compares each one with the incrementing pattern,
// keeping a word count, a saturating error count and the first error index.
//
// FIFO read handshake: fifo_read_enable is a strobe that is only raised when
// fifo_empty is low in the same cycle; the FIFO presents the strobed word on
// fifo_out exactly one cycle later, which is when rd_q is high and the word
// is compared. There is no back-pressure on the returned data.
module fifo_rd_checker
    import fifo_test_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 11,
    parameter int BURST_LEN = 1024,
    parameter int SEED      = 0,
    parameter int ERR_W     = 8
) (
    input  logic              CLOCK,
    input  logic              RdReset,
    input  logic              isStartR,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_out,
    output logic              fifo_read_enable,
    output logic [3:0]        RSTATE,
    output logic [CNT_W-1:0]  r_cnt,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] BURST_CNT  = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [ERR_W-1:0] ERR_MAX    = '1;
    localparam logic [CNT_W-1:0] NO_ERR_IDX = '1;

    fifo_state_e       state;
    logic [CNT_W-1:0]  iss_cnt;
    logic              rd_q;
    logic [DATA_W-1:0] exp_word;
    logic              word_bad;

    // Read strobe follows the current-cycle empty flag so the FIFO never underflows.
    always_comb begin
        fifo_read_enable = (state == READ) && !fifo_empty && (iss_cnt < BURST_CNT);
    end

    // Expected word for the data returning this cycle, and whether it differs.
    always_comb begin
        exp_word = DATA_W'(next(32'(SEED), 32'(r_cnt)));
        word_bad = (fifo_out != exp_word);
    end

    // Control FSM, issue counter, read-data pipeline and result counters.
    always_ff @(posedge CLOCK) begin
        if (RdReset) begin
            state         <= IDLE;
            iss_cnt       <= '0;
            rd_q          <= 1'b0;
            r_cnt         <= '0;
            err_cnt       <= '0;
            first_err_idx <= NO_ERR_IDX;
        end else begin
            rd_q <= fifo_read_enable;

            if (fifo_read_enable) begin
                iss_cnt <= iss_cnt + 1'b1;
            end

            // Check the word strobed on the previous edge.
            if (rd_q) begin
                if (word_bad) begin
                    if (err_cnt != ERR_MAX) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                    if (err_cnt == '0) begin
                        first_err_idx <= r_cnt;
                    end
                end
                r_cnt <= r_cnt + 1'b1;
            end

            case (state)
                IDLE, DONE: begin
                    // Starting a run clears everything left from the last one.
                    if (isStartR) begin
                        state         <= READ;
                        iss_cnt       <= '0;
                        rd_q          <= 1'b0;
                        r_cnt         <= '0;
                        err_cnt       <= '0;
                        first_err_idx <= NO_ERR_IDX;
                    end
                end
                READ: begin
                    if (fifo_read_enable && (iss_cnt == BURST_LAST)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rd_q && (r_cnt == BURST_LAST)) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status outputs decode straight from the state register.
    always_comb begin
        RSTATE = state;
        busy   = (state == READ) || (state == DRAIN);
        done   = (state == DONE);
    end

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Directed bench for fifo_rd_checker: a behavioural FIFO with optional stalls
// feeds the default instance; a second instance with ERR_W=4 sees all-zero data.
module tb_fifo_rd_checker;

    localparam int DATA_W    = 8;
    localparam int CNT_W     = 11;
    localparam int BURST_LEN = 1024;

    // ---------------- clock / reset ----------------
    logic CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    logic RdReset  = 1'b1;
    logic isStartR = 1'b0;

    // ---------------- main DUT ----------------
    logic              fifo_empty = 1'b0;
    logic [DATA_W-1:0] fifo_out   = '0;
    logic              fifo_read_enable;
    logic [3:0]        RSTATE;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        err_cnt;
    logic [CNT_W-1:0]  first_err_idx;
    logic              busy;
    logic              done;

    fifo_rd_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W), .BURST_LEN(BURST_LEN),
                      .SEED(0), .ERR_W(8)) dut (
        .CLOCK(CLOCK), .RdReset(RdReset), .isStartR(isStartR),
        .fifo_empty(fifo_empty), .fifo_out(fifo_out),
        .fifo_read_enable(fifo_read_enable), .RSTATE(RSTATE), .r_cnt(r_cnt),
        .err_cnt(err_cnt), .first_err_idx(first_err_idx), .busy(busy), .done(done)
    );

    // ---------------- saturation DUT (ERR_W=4, zero data) ----------------
    logic              sat_reset = 1'b1;
    logic              sat_start = 1'b0;
    logic              sat_empty = 1'b0;
    logic [DATA_W-1:0] sat_data  = '0;
    logic              sat_rd_en;
    logic [3:0]        sat_state;
    logic [CNT_W-1:0]  sat_r_cnt;
    logic [3:0]        sat_err;
    logic [CNT_W-1:0]  sat_first;
    logic              sat_busy;
    logic              sat_done;

    fifo_rd_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W), .BURST_LEN(BURST_LEN),
                      .SEED(0), .ERR_W(4)) dut_sat (
        .CLOCK(CLOCK), .RdReset(sat_reset), .isStartR(sat_start),
        .fifo_empty(sat_empty), .fifo_out(sat_data),
        .fifo_read_enable(sat_rd_en), .RSTATE(sat_state), .r_cnt(sat_r_cnt),
        .err_cnt(sat_err), .first_err_idx(sat_first), .busy(sat_busy), .done(sat_done)
    );

    // ---------------- FIFO model ----------------
    logic [DATA_W-1:0] mem [0:BURST_LEN-1];
    logic [10:0]       ptr        = '0;   // doubles as the strobe count of a run
    int                stall_left = 0;
    logic              stall_en   = 1'b0;
    logic              tb_rewind  = 1'b0;
    int                empty_viol = 0;

    // One-cycle read latency; optional 5-cycle empty window after every 100 words.
    always @(posedge CLOCK) begin
        if (tb_rewind) begin
            ptr        <= '0;
            stall_left <= 0;
            fifo_empty <= 1'b0;
        end else if (fifo_read_enable) begin
            fifo_out <= mem[ptr[9:0]];
            ptr      <= ptr + 1'b1;
            if (stall_en && ((32'(ptr) + 1) % 100 == 0)) begin
                fifo_empty <= 1'b1;
                stall_left <= 5;
            end
        end else if (stall_left != 0) begin
            stall_left <= stall_left - 1;
            if (stall_left == 1) fifo_empty <= 1'b0;
        end
    end

    always @(negedge CLOCK) begin
        if (fifo_read_enable && fifo_empty) empty_viol++;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_pattern();
        for (int i = 0; i < BURST_LEN; i++) mem[i] = DATA_W'(i);
    endtask

    task automatic rewind_fifo();
        tb_rewind = 1'b1;
        @(posedge CLOCK);
        #1 tb_rewind = 1'b0;
    endtask

    // Raise isStartR for 'hold' cycles; 'cycles' counts from the start cycle
    // (start cycle = 0) to the cycle in which done is seen high.
    task automatic run_burst(input string tag, input int hold, output int cycles);
        rewind_fifo();
        isStartR = 1'b1;
        cycles   = 0;
        while (cycles < 5000) begin
            @(posedge CLOCK);
            cycles++;
            #1;
            if (cycles >= hold) isStartR = 1'b0;
            if (cycles == 1) begin
                check({tag, "_entry_state"}, 32'(RSTATE), 32'd1);
                check({tag, "_entry_strobe"}, 32'(fifo_read_enable), 32'd1);
                check({tag, "_entry_rcnt"}, 32'(r_cnt), 32'd0);
                check({tag, "_entry_first"}, 32'(first_err_idx), 32'd2047);
            end
            if (done) break;
        end
        isStartR = 1'b0;
        if (!done) check({tag, "_done_timeout"}, 32'(done), 32'd1);
    endtask

    // ---------------- test sequence ----------------
    int cyc;

    initial begin
        load_pattern();
        repeat (3) @(posedge CLOCK);
        #1;
        check("rst_state", 32'(RSTATE), 32'd0);
        check("rst_rcnt", 32'(r_cnt), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        check("rst_first", 32'(first_err_idx), 32'd2047);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_strobe", 32'(fifo_read_enable), 32'd0);
        RdReset = 1'b0;

        // Clean burst with isStartR held high well into READ.
        run_burst("clean", 50, cyc);
        check("clean_done_cycle", 32'(cyc), 32'd1026);
        check("clean_rcnt", 32'(r_cnt), 32'd1024);
        check("clean_err", 32'(err_cnt), 32'd0);
        check("clean_first", 32'(first_err_idx), 32'd2047);
        check("clean_strobes", 32'(ptr), 32'd1024);
        check("clean_state", 32'(RSTATE), 32'd3);
        repeat (10) @(posedge CLOCK);
        #1;
        check("hold_rcnt", 32'(r_cnt), 32'd1024);
        check("hold_done", {30'd0, busy, done}, 32'd1);

        // Stalls: 10 windows of 5 empty cycles.
        stall_en = 1'b1;
        run_burst("stall", 1, cyc);
        stall_en = 1'b0;
        check("stall_done_cycle", 32'(cyc), 32'd1076);
        check("stall_err", 32'(err_cnt), 32'd0);
        check("stall_strobes", 32'(ptr), 32'd1024);
        check("stall_no_strobe_empty", 32'(empty_viol), 32'd0);

        // Corruption at words 37 (exp 0x25) and 500 (exp 0xF4).
        mem[37]  = 8'hFF;
        mem[500] = 8'h00;
        run_burst("corrupt", 1, cyc);
        check("corrupt_done_cycle", 32'(cyc), 32'd1026);
        check("corrupt_err", 32'(err_cnt), 32'd2);
        check("corrupt_first", 32'(first_err_idx), 32'd37);
        check("corrupt_rcnt", 32'(r_cnt), 32'd1024);

        // Restart from DONE clears results, then reset mid-burst at r_cnt=300.
        rewind_fifo();
        isStartR = 1'b1;
        @(posedge CLOCK);
        #1 isStartR = 1'b0;
        check("restart_state", 32'(RSTATE), 32'd1);
        check("restart_err", 32'(err_cnt), 32'd0);
        check("restart_first", 32'(first_err_idx), 32'd2047);
        check("restart_rcnt", 32'(r_cnt), 32'd0);
        cyc = 0;
        while (r_cnt != 11'd300 && cyc < 2000) begin
            @(posedge CLOCK);
            #1 cyc++;
        end
        check("midrst_reached_300", 32'(r_cnt), 32'd300);
        check("midrst_err_before", 32'(err_cnt), 32'd1);
        RdReset = 1'b1;
        @(posedge CLOCK);
        #1;
        check("midrst_state", 32'(RSTATE), 32'd0);
        check("midrst_rcnt", 32'(r_cnt), 32'd0);
        check("midrst_err", 32'(err_cnt), 32'd0);
        check("midrst_first", 32'(first_err_idx), 32'd2047);
        check("midrst_strobe", 32'(fifo_read_enable), 32'd0);
        check("midrst_busy_done", {30'd0, busy, done}, 32'd0);
        RdReset = 1'b0;
        mem[37]  = 8'h25;
        mem[500] = 8'hF4;
        run_burst("after_rst", 1, cyc);
        check("after_rst_done_cycle", 32'(cyc), 32'd1026);
        check("after_rst_err", 32'(err_cnt), 32'd0);
        check("after_rst_rcnt", 32'(r_cnt), 32'd1024);

        // Saturation: all-zero data into the ERR_W=4 instance.
        sat_reset = 1'b0;
        sat_start = 1'b1;
        @(posedge CLOCK);
        #1 sat_start = 1'b0;
        cyc = 1;
        while (!sat_done && cyc < 3000) begin
            @(posedge CLOCK);
            #1 cyc++;
        end
        check("sat_done", 32'(sat_done), 32'd1);
        check("sat_done_cycle", 32'(cyc), 32'd1026);
        check("sat_err", 32'(sat_err), 32'd15);
        check("sat_first", 32'(sat_first), 32'd1);
        check("sat_rcnt", 32'(sat_r_cnt), 32'd1024);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
